car_request_latch: RTL and testbench

//   Upstream conditioning stage for the traffic light controller. Takes raw,

---
 rtl/car_request_latch.sv | 100 ++++++++++
 tb/tb_car_request_latch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/car_request_latch.sv
// car_request_latch: synchronises and debounces the EW/NS loop sensors, latches each
// arrival as a pending request, and presents it once the current green has run MIN_GREEN cycles.
module car_request_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GREEN       = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ew_sensor,
  input  logic ns_sensor,
  input  logic ns_green,
  output logic EWCar,
  output logic NSCar,
  output logic ew_pending,
  output logic ns_pending
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = $clog2(MIN_GREEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(MIN_GREEN);

  // Per-direction vectors: index 0 = EW, index 1 = NS
  logic [1:0]       raw;
  logic [1:0]       served;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       db_p2;
  logic [1:0]       db_p3;
  logic [1:0]       db_nxt;
  logic [1:0]       rise;
  logic [1:0]       pend;
  logic [1:0]       pend_nxt;
  logic [CNT_W-1:0] cnt     [2];
  logic [CNT_W-1:0] cnt_nxt [2];
  logic             prev_ns_green;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             timer_done;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_MAX) ? v : v + TMR_W'(1);
  endfunction

  assign raw        = {ns_sensor, ew_sensor};
  assign served     = {ns_green, ~ns_green};
  assign rise       = db_p2 & ~db_p3;
  assign timer_done = (timer == TMR_MAX);
  assign timer_nxt  = (ns_green != prev_ns_green) ? '0 : sat_inc(timer);
  assign ew_pending = pend[0];
  assign ns_pending = pend[1];

  always_comb begin
    db_nxt   = db_p2;
    pend_nxt = pend;
    for (int i = 0; i < 2; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] != db_p2[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_nxt[i] = sync_p1[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
      // Serving a direction discards its request even if a new edge arrives this cycle
      pend_nxt[i] = served[i] ? 1'b0 : (pend[i] | rise[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0       <= '0;
      sync_p1       <= '0;
      db_p2         <= '0;
      db_p3         <= '0;
      pend          <= '0;
      cnt[0]        <= '0;
      cnt[1]        <= '0;
      prev_ns_green <= ns_green;
      timer         <= '0;
      EWCar         <= 1'b0;
      NSCar         <= 1'b0;
    end else begin
      // p0/p1: two-flop synchroniser
      sync_p0       <= raw;
      sync_p1       <= sync_p0;
      // p2: debounced level; p3: its delayed copy for edge detection
      db_p2         <= db_nxt;
      db_p3         <= db_p2;
      cnt[0]        <= cnt_nxt[0];
      cnt[1]        <= cnt_nxt[1];
      pend          <= pend_nxt;
      prev_ns_green <= ns_green;
      timer         <= timer_nxt;
      EWCar         <= pend[0] &  ns_green & timer_done;
      NSCar         <= pend[1] & ~ns_green & timer_done;
    end
  end

endmodule

// File: tb/tb_car_request_latch.sv
// Directed bench for car_request_latch: stimulus pushes per-cycle expectations into a
// scoreboard queue; a negedge monitor compares every entry due on the current cycle.
module tb_car_request_latch;

  localparam int S_EWCAR = 0;
  localparam int S_NSCAR = 1;
  localparam int S_EWP   = 2;
  localparam int S_NSP   = 3;

  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } exp_t;

  logic clock;
  logic reset;
  logic ew_sensor;
  logic ns_sensor;
  logic ns_green;
  logic EWCar;
  logic NSCar;
  logic ew_pending;
  logic ns_pending;

  int   cyc;
  exp_t sb[$];
  bit   done;
  int   vectors;
  int   miscompares;
  int   checked;

  car_request_latch #(
    .DEBOUNCE_CYCLES(4),
    .MIN_GREEN      (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ew_sensor (ew_sensor),
    .ns_sensor (ns_sensor),
    .ns_green  (ns_green),
    .EWCar     (EWCar),
    .NSCar     (NSCar),
    .ew_pending(ew_pending),
    .ns_pending(ns_pending)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // cyc == N from edge N until edge N+1
  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_EWCAR: return "EWCar";
      S_NSCAR: return "NSCar";
      S_EWP:   return "ew_pending";
      default: return "ns_pending";
    endcase
  endfunction

  function automatic logic sig_val(input int s);
    case (s)
      S_EWCAR: return EWCar;
      S_NSCAR: return NSCar;
      S_EWP:   return ew_pending;
      default: return ns_pending;
    endcase
  endfunction

  task automatic expect_rng(input int c0, input int c1, input int s, input logic v);
    for (int c = c0; c <= c1; c++) sb.push_back('{cyc: c, sig: s, val: v});
  endtask

  task automatic expect_all0(input int c);
    for (int s = 0; s < 4; s++) sb.push_back('{cyc: c, sig: s, val: 1'b0});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Monitor: compare every expectation due this cycle, plus request exclusivity
  always @(negedge clock) begin
    if (done) begin
      vectors = vectors + 1;
      if (checked != sb.size()) begin
        miscompares = miscompares + 1;
        $display("FAIL scoreboard_drain: checked %0d entries, required %0d", checked, sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else begin
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].cyc == cyc) begin
          vectors = vectors + 1;
          checked = checked + 1;
          if (sig_val(sb[i].sig) !== sb[i].val) begin
            miscompares = miscompares + 1;
            $display("FAIL %s @cyc %0d: got %b, required %b",
                     sig_name(sb[i].sig), cyc, sig_val(sb[i].sig), sb[i].val);
          end
        end
      end
      if (cyc >= 3) begin
        vectors = vectors + 1;
        if (EWCar && NSCar) begin
          miscompares = miscompares + 1;
          $display("FAIL exclusive @cyc %0d: EWCar=%b NSCar=%b, required not both 1", cyc, EWCar, NSCar);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t reached at cyc %0d, required done", $time, cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    checked     = 0;
    done        = 1'b0;
    reset       = 1'b1;
    ns_green    = 1'b1;
    ew_sensor   = 1'b0;
    ns_sensor   = 1'b0;

    // Reset two cycles; NS green; EW arrives at edge 12
    expect_all0(1);
    expect_all0(2);
    expect_rng(3, 18, S_EWP, 1'b0);
    expect_rng(19, 24, S_EWP, 1'b1);
    expect_rng(3, 19, S_EWCAR, 1'b0);
    expect_rng(20, 24, S_EWCAR, 1'b1);
    expect_rng(3, 47, S_NSCAR, 1'b0);
    expect_rng(3, 46, S_NSP, 1'b0);
    wait_until(2);
    reset = 1'b0;
    wait_until(12);
    ew_sensor = 1'b1;

    // Green moves to EW: EW request dropped, car leaves the loop
    wait_until(24);
    expect_rng(25, 52, S_EWP, 1'b0);
    expect_rng(26, 52, S_EWCAR, 1'b0);
    ns_green  = 1'b0;
    ew_sensor = 1'b0;

    // Both approaches arrive together while EW is green
    wait_until(40);
    expect_rng(47, 52, S_NSP, 1'b1);
    expect_rng(48, 52, S_NSCAR, 1'b1);
    ew_sensor = 1'b1;
    ns_sensor = 1'b1;

    // One-cycle reset while both sensors stay held
    wait_until(52);
    expect_all0(53);
    expect_rng(54, 59, S_NSP, 1'b0);
    expect_rng(60, 64, S_NSP, 1'b1);
    expect_rng(54, 61, S_NSCAR, 1'b0);
    expect_rng(62, 64, S_NSCAR, 1'b1);
    expect_rng(54, 170, S_EWP, 1'b0);
    expect_rng(54, 170, S_EWCAR, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // NS green; short EW glitch (3 synced cycles) once timer is saturated
    wait_until(64);
    expect_rng(65, 166, S_NSP, 1'b0);
    expect_rng(65, 167, S_NSCAR, 1'b0);
    ns_green  = 1'b1;
    ew_sensor = 1'b0;
    wait_until(76);
    ew_sensor = 1'b1;
    wait_until(79);
    ew_sensor = 1'b0;

    // EW green; NS sensor settles low, then chatters every cycle for 50 cycles
    wait_until(96);
    ns_green  = 1'b0;
    ns_sensor = 1'b0;
    wait_until(106);
    for (int i = 0; i < 50; i++) begin
      ns_sensor = ~ns_sensor;
      tick();
    end
    ns_sensor = 1'b0;

    // A clean NS arrival after the chatter still gets through
    wait_until(160);
    expect_rng(167, 170, S_NSP, 1'b1);
    expect_rng(168, 170, S_NSCAR, 1'b1);
    ns_sensor = 1'b1;

    wait_until(172);
    done = 1'b1;
  end

endmodule
